sorted_stream_out: RTL and testbench

SORTED_STREAM_OUT -- requirements
Module: sorted_stream_out

---
 rtl/sorted_stream_out.sv | 95 +++++++++
 tb/tb_sorted_stream_out.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sorted_stream_out.sv
// Buffers one sorted array from the upstream sorter and replays it as a
// valid/ready word stream in ascending or descending index order.
module sorted_stream_out #(
  parameter  int DATA_N = 4,
  parameter  int DATA_W = 4,
  localparam int IW     = (DATA_N > 1) ? $clog2(DATA_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in [DATA_N],
  input  logic              load,
  input  logic              desc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IW-1:0]     m_index,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_buf [DATA_N];
  logic              r_desc;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_done;
  logic              r_ovr;

  logic              w_xfer;
  logic              w_accept;
  logic [IW-1:0]     w_nidx;
  logic              w_nlast;

  assign w_xfer   = (r_state == STREAM) && m_ready;
  // A load is taken when idle, or when it coincides with the final transfer.
  assign w_accept = load && ((r_state == IDLE) || (w_xfer && r_last));
  assign w_nidx   = r_desc ? (r_idx - 1'b1) : (r_idx + 1'b1);
  assign w_nlast  = r_desc ? (w_nidx == '0) : (w_nidx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_desc  <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      for (int i = 0; i < DATA_N; i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        for (int i = 0; i < DATA_N; i++) r_buf[i] <= data_in[i];
        r_desc  <= desc;
        r_state <= STREAM;
        r_idx   <= desc ? LAST_IDX : '0;
        r_data  <= desc ? data_in[DATA_N-1] : data_in[0];
        r_last  <= (DATA_N == 1);
        r_ovr   <= 1'b0;
        r_done  <= w_xfer;
      end else begin
        if (load) r_ovr <= 1'b1;
        if (w_xfer) begin
          if (r_last) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= w_nidx;
            r_data  <= r_buf[w_nidx];
            r_last  <= w_nlast;
          end
        end
      end
    end
  end

  assign busy       = (r_state == STREAM);
  assign m_valid    = busy;
  assign m_data     = r_data;
  assign m_index    = r_idx;
  assign m_last     = r_last;
  assign frame_done = r_done;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_sorted_stream_out.sv
// Directed bench for sorted_stream_out (DATA_N=4, DATA_W=4): ordering,
// stalls, overrun, back-to-back frames and asynchronous reset.
module tb_sorted_stream_out;

  logic       clk;
  logic       rst_n;
  logic [3:0] din [4];
  logic       load;
  logic       desc;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic [1:0] m_index;
  logic       m_last;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int n_chk = 0;
  int n_fail = 0;

  sorted_stream_out #(.DATA_N(4), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(din), .load(load), .desc(desc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wchk(input string tag, input int d, input int idx, input int last);
    chk({tag, "_valid"}, int'(m_valid), 1);
    chk({tag, "_data"},  int'(m_data),  d);
    chk({tag, "_index"}, int'(m_index), idx);
    chk({tag, "_last"},  int'(m_last),  last);
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d, input bit dsc);
    din[0] = 4'(a);
    din[1] = 4'(b);
    din[2] = 4'(c);
    din[3] = 4'(d);
    desc = dsc;
    load = 1'b1;
  endtask

  int       e0 [4] = '{1, 3, 7, 9};
  bit [3:0] pat = 4'b1001;

  initial begin
    int k;
    int c;
    rst_n = 1'b0; load = 1'b0; desc = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = '0;

    #12;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_data",  int'(m_data), 0);
    chk("rst_index", int'(m_index), 0);
    chk("rst_last",  int'(m_last), 0);
    chk("rst_done",  int'(frame_done), 0);
    chk("rst_ovr",   int'(overrun), 0);

    // load on the first edge after reset release, ascending
    @(negedge clk);
    rst_n = 1'b1;
    do_load(1, 3, 7, 9, 0);
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wchk("A", e0[i], i, int'(i == 3));
      chk("A_busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("A_done",  int'(frame_done), 1);
    chk("A_idle",  int'(m_valid), 0);
    chk("A_data0", int'(m_data), 0);
    @(negedge clk);
    chk("A_done_pulse", int'(frame_done), 0);

    // descending
    do_load(1, 3, 7, 9, 1);
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wchk("B", e0[3-i], 3 - i, int'(i == 3));
      @(negedge clk);
    end
    chk("B_done", int'(frame_done), 1);
    @(negedge clk);

    // stalls: ready pattern 1,0,0,1 repeating
    do_load(1, 3, 7, 9, 0);
    @(negedge clk); load = 1'b0;
    k = 0; c = 0;
    while (k < 4 && c < 40) begin
      wchk("C", e0[k], k, int'(k == 3));
      m_ready = pat[c % 4];
      if (m_ready) k++;
      c++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    chk("C_xfers", k, 4);
    chk("C_cycles", c, 8);
    chk("C_done", int'(frame_done), 1);
    @(negedge clk);

    // load during the 2nd transfer is dropped and flagged
    do_load(1, 3, 7, 9, 0);
    @(negedge clk); load = 1'b0;
    wchk("D0", 1, 0, 0);
    @(negedge clk);
    wchk("D1", 3, 1, 0);
    do_load(15, 15, 15, 15, 1);
    @(negedge clk); load = 1'b0;
    chk("D_ovr", int'(overrun), 1);
    wchk("D2", 7, 2, 0);
    @(negedge clk);
    wchk("D3", 9, 3, 1);
    @(negedge clk);
    chk("D_done", int'(frame_done), 1);
    chk("D_ovr_sticky", int'(overrun), 1);

    // accepted load clears overrun; load coincident with last transfer
    do_load(1, 3, 7, 9, 0);
    @(negedge clk); load = 1'b0;
    chk("E_ovr_clr", int'(overrun), 0);
    wchk("E0", 1, 0, 0);
    @(negedge clk); wchk("E1", 3, 1, 0);
    @(negedge clk); wchk("E2", 7, 2, 0);
    @(negedge clk); wchk("E3", 9, 3, 1);
    do_load(0, 2, 4, 6, 0);
    @(negedge clk); load = 1'b0;
    chk("E_done", int'(frame_done), 1);
    chk("E_ovr", int'(overrun), 0);
    wchk("En0", 0, 0, 0);
    @(negedge clk); wchk("En1", 2, 1, 0);
    @(negedge clk); wchk("En2", 4, 2, 0);
    @(negedge clk); wchk("En3", 6, 3, 1);
    @(negedge clk);
    chk("En_done", int'(frame_done), 1);

    // asynchronous reset after two transfers
    do_load(1, 3, 7, 9, 0);
    @(negedge clk); load = 1'b0;
    wchk("F0", 1, 0, 0);
    @(negedge clk);
    wchk("F1", 3, 1, 0);
    load = 1'b1;
    @(negedge clk); load = 1'b0;
    wchk("F2", 7, 2, 0);
    chk("F_ovr", int'(overrun), 1);
    rst_n = 1'b0;
    #1;
    chk("F_valid", int'(m_valid), 0);
    chk("F_busy",  int'(busy), 0);
    chk("F_data",  int'(m_data), 0);
    chk("F_index", int'(m_index), 0);
    chk("F_last",  int'(m_last), 0);
    chk("F_done",  int'(frame_done), 0);
    chk("F_ovr0",  int'(overrun), 0);
    @(negedge clk);
    chk("F_no_done", int'(frame_done), 0);
    rst_n = 1'b1;
    do_load(5, 6, 7, 8, 1);
    @(negedge clk); load = 1'b0;
    wchk("G0", 8, 3, 0);
    @(negedge clk); wchk("G1", 7, 2, 0);
    @(negedge clk); wchk("G2", 6, 1, 0);
    @(negedge clk); wchk("G3", 5, 0, 1);
    @(negedge clk);
    chk("G_done", int'(frame_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
